// File: rtl/spi_master_xfer.sv
// SPI mode-0 initiator: one nbits word per val/rdy request, received word on val/rdy response.
// Optional macro SPI_MASTER_MISO_SYNC_EN adds a 2-flop synchronizer on spi_miso.
module spi_master_xfer #(
  parameter int nbits       = 8,
  parameter int half_period = 4,
  parameter int ncs         = 1,
  localparam int AW         = (ncs > 1) ? $clog2(ncs) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_val,
  output logic             send_rdy,
  input  logic [nbits-1:0] send_msg,
  input  logic [AW-1:0]    cs_addr,
  output logic             recv_val,
  input  logic             recv_rdy,
  output logic [nbits-1:0] recv_msg,
  output logic             spi_sclk,
  output logic [ncs-1:0]   spi_cs,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int PW = (half_period > 1) ? $clog2(half_period) : 1;
  localparam int BW = $clog2(nbits);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    phase, phase_nxt;
  logic [BW-1:0]    bitc, bitc_nxt;
  logic [nbits-1:0] shreg, shreg_nxt;
  logic [nbits-1:0] recv_msg_nxt;
  logic [AW-1:0]    sel, sel_nxt;
  logic             sample, sample_nxt;
  logic             sclk_nxt, mosi_nxt, active, phase_last, miso_in, shift_bit;
  logic [ncs-1:0]   cs_nxt;

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic miso_s1, miso_s2;
  always_ff @(posedge clk) begin
    miso_s1 <= spi_miso;
    miso_s2 <= miso_s1;
  end
  assign miso_in = miso_s2;
`else
  assign miso_in = spi_miso;
`endif

  assign send_rdy   = (state == IDLE) && !reset;
  assign recv_val   = (state == DONE);
  assign phase_last = (phase == PW'(half_period - 1));
  // With half_period=1 the HIGH entry cycle is also its last, so shift miso in directly.
  assign shift_bit  = (phase == '0) ? miso_in : sample;

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    bitc_nxt     = bitc;
    shreg_nxt    = shreg;
    sel_nxt      = sel;
    sample_nxt   = sample;
    recv_msg_nxt = recv_msg;
    case (state)
      IDLE: if (send_val && send_rdy) begin
        shreg_nxt = send_msg;
        sel_nxt   = cs_addr;
        phase_nxt = '0;
        bitc_nxt  = '0;
        state_nxt = SETUP;
      end
      SETUP, LOW: begin
        if (phase_last) begin
          phase_nxt = '0;
          state_nxt = HIGH;
        end else phase_nxt = phase + 1'b1;
      end
      HIGH: begin
        if (phase == '0) sample_nxt = miso_in;
        if (phase_last) begin
          phase_nxt = '0;
          shreg_nxt = {shreg[nbits-2:0], shift_bit};
          if (bitc == BW'(nbits - 1)) state_nxt = HOLD;
          else begin
            bitc_nxt  = bitc + 1'b1;
            state_nxt = LOW;
          end
        end else phase_nxt = phase + 1'b1;
      end
      HOLD: begin
        if (phase_last) begin
          phase_nxt    = '0;
          recv_msg_nxt = shreg;
          state_nxt    = DONE;
        end else phase_nxt = phase + 1'b1;
      end
      DONE: if (recv_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SPI pins are registered from the next-state view so they change with the state.
  always_comb begin
    active   = (state_nxt == SETUP) || (state_nxt == HIGH) ||
               (state_nxt == LOW) || (state_nxt == HOLD);
    sclk_nxt = (state_nxt == HIGH);
    cs_nxt   = '1;
    for (int i = 0; i < ncs; i++) begin
      if (active && (int'(sel_nxt) == i)) cs_nxt[i] = 1'b0;
    end
    case (state_nxt)
      SETUP, LOW: mosi_nxt = shreg_nxt[nbits-1];
      HIGH, HOLD: mosi_nxt = spi_mosi;
      default:    mosi_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      bitc     <= '0;
      recv_msg <= '0;
      spi_sclk <= 1'b0;
      spi_cs   <= '1;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bitc     <= bitc_nxt;
      recv_msg <= recv_msg_nxt;
      spi_sclk <= sclk_nxt;
      spi_cs   <= cs_nxt;
      spi_mosi <= mosi_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg  <= shreg_nxt;
    sel    <= sel_nxt;
    sample <= sample_nxt;
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: minion model on a 2-select instance, loopback on a fast instance.
module tb_spi_master_xfer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance A: nbits=8, half_period=4, ncs=2
  logic       send_val_a, send_rdy_a, recv_val_a, recv_rdy_a;
  logic [7:0] send_msg_a, recv_msg_a;
  logic       cs_addr_a, spi_sclk_a, spi_mosi_a, spi_miso_a;
  logic [1:0] spi_cs_a;

  spi_master_xfer #(.nbits(8), .half_period(4), .ncs(2)) u_a (
    .clk(clk), .reset(reset),
    .send_val(send_val_a), .send_rdy(send_rdy_a), .send_msg(send_msg_a), .cs_addr(cs_addr_a),
    .recv_val(recv_val_a), .recv_rdy(recv_rdy_a), .recv_msg(recv_msg_a),
    .spi_sclk(spi_sclk_a), .spi_cs(spi_cs_a), .spi_mosi(spi_mosi_a), .spi_miso(spi_miso_a)
  );

  // Instance B: nbits=8, half_period=1, ncs=1, loopback
  logic       send_val_b, send_rdy_b, recv_val_b, recv_rdy_b;
  logic [7:0] send_msg_b, recv_msg_b;
  logic       cs_addr_b, spi_sclk_b, spi_mosi_b;
  logic [0:0] spi_cs_b;

  spi_master_xfer #(.nbits(8), .half_period(1), .ncs(1)) u_b (
    .clk(clk), .reset(reset),
    .send_val(send_val_b), .send_rdy(send_rdy_b), .send_msg(send_msg_b), .cs_addr(cs_addr_b),
    .recv_val(recv_val_b), .recv_rdy(recv_rdy_b), .recv_msg(recv_msg_b),
    .spi_sclk(spi_sclk_b), .spi_cs(spi_cs_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_mosi_b)
  );

  // Minion model for A: presents MSB while selected, shifts on SCLK falling edges.
  logic [7:0] resp_a = 8'h00;
  logic [7:0] mshr_a = 8'h00;
  logic       const_mode = 1'b0;
  logic       const_val = 1'b0;
  assign spi_miso_a = const_mode ? const_val : mshr_a[7];

  int         cyc_a = 0, cs_first_a = -1, cs_last_a = -1, rise_a = 0, first_rise_a = -1, rv_first_a = -1;
  logic       prev_sclk_a = 1'b0;
  logic [7:0] mosi_bits_a = 8'h00;
  logic [1:0] cs_seen_a = 2'b11;

  always @(negedge clk) begin
    if (send_val_a && send_rdy_a) begin
      cyc_a = 0; cs_first_a = -1; cs_last_a = -1; rise_a = 0; first_rise_a = -1; rv_first_a = -1;
    end else cyc_a++;
    if (spi_cs_a != 2'b11) begin
      if (cs_first_a < 0) cs_first_a = cyc_a;
      cs_last_a = cyc_a;
      cs_seen_a = spi_cs_a;
    end
    if (spi_sclk_a && !prev_sclk_a) begin
      rise_a++;
      if (first_rise_a < 0) first_rise_a = cyc_a;
      mosi_bits_a = {mosi_bits_a[6:0], spi_mosi_a};
    end
    if (recv_val_a && rv_first_a < 0) rv_first_a = cyc_a;
    if (spi_cs_a == 2'b11) mshr_a = resp_a;
    else if (prev_sclk_a && !spi_sclk_a) mshr_a = {mshr_a[6:0], 1'b0};
    prev_sclk_a = spi_sclk_a;
  end

  int   cyc_b = 0, cslow_b = 0, rise_b = 0, tog_b = 0, first_rise_b = -1;
  logic prev_sclk_b = 1'b0;

  always @(negedge clk) begin
    if (send_val_b && send_rdy_b) begin
      cyc_b = 0; cslow_b = 0; rise_b = 0; tog_b = 0; first_rise_b = -1;
    end else cyc_b++;
    if (!spi_cs_b[0]) cslow_b++;
    if (spi_sclk_b != prev_sclk_b) tog_b++;
    if (spi_sclk_b && !prev_sclk_b) begin
      rise_b++;
      if (first_rise_b < 0) first_rise_b = cyc_b;
    end
    prev_sclk_b = spi_sclk_b;
  end

  task automatic run_a(input string tag, input logic [7:0] tx, input logic [7:0] rsp,
                       input logic sel, input int hold, input logic [7:0] exp);
    int t;
    resp_a = rsp; send_msg_a = tx; cs_addr_a = sel; recv_rdy_a = 1'b0; send_val_a = 1'b1;
    t = 0;
    while (!send_rdy_a && t < 50) begin @(posedge clk); #1; t++; end
    chk({tag, "_rdy_wait"}, t < 50, 1);
    @(posedge clk); #1;
    send_val_a = 1'b0;
    t = 0;
    while (!recv_val_a && t < 200) begin @(posedge clk); #1; t++; end
    chk({tag, "_val_wait"}, t < 200, 1);
    chk({tag, "_rx"}, recv_msg_a, exp);
    chk({tag, "_rises"}, rise_a, 8);
    chk({tag, "_mosi"}, mosi_bits_a, tx);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {recv_val_a, send_rdy_a, spi_cs_a, recv_msg_a}, {1'b1, 1'b0, 2'b11, exp});
    end
    recv_rdy_a = 1'b1;
    @(posedge clk); #1;
    recv_rdy_a = 1'b0;
    chk({tag, "_idle_after"}, {send_rdy_a, recv_val_a, spi_cs_a}, {1'b1, 1'b0, 2'b11});
  endtask

  task automatic run_b(input string tag, input logic [7:0] tx, input logic sel, input int exp_cslow);
    int t;
    send_msg_b = tx; cs_addr_b = sel; recv_rdy_b = 1'b0; send_val_b = 1'b1;
    t = 0;
    while (!send_rdy_b && t < 50) begin @(posedge clk); #1; t++; end
    chk({tag, "_rdy_wait"}, t < 50, 1);
    @(posedge clk); #1;
    send_val_b = 1'b0;
    t = 0;
    while (!recv_val_b && t < 100) begin @(posedge clk); #1; t++; end
    chk({tag, "_val_wait"}, t < 100, 1);
`ifndef SPI_MASTER_MISO_SYNC_EN
    chk({tag, "_loopback"}, recv_msg_b, tx);
`endif
    chk({tag, "_cs_low_cycles"}, cslow_b, exp_cslow);
    chk({tag, "_rises"}, rise_b, 8);
    chk({tag, "_toggles"}, tog_b, 16);
    chk({tag, "_first_rise"}, first_rise_b, 2);
    recv_rdy_b = 1'b1;
    @(posedge clk); #1;
    recv_rdy_b = 1'b0;
    chk({tag, "_idle_after"}, send_rdy_b, 1);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    send_val_a = 1'b0; send_msg_a = 8'h00; cs_addr_a = 1'b0; recv_rdy_a = 1'b0;
    send_val_b = 1'b0; send_msg_b = 8'h00; cs_addr_b = 1'b0; recv_rdy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", send_rdy_a, 0);
    chk("reset_outs", {spi_sclk_a, spi_cs_a, spi_mosi_a, recv_val_a, recv_msg_a},
        {1'b0, 2'b11, 1'b0, 1'b0, 8'h00});
    chk("reset_outs_b", {spi_sclk_b, spi_cs_b, spi_mosi_b, recv_val_b}, {1'b0, 1'b1, 1'b0, 1'b0});
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_rdy", send_rdy_a, 1);

    run_a("a5", 8'hA5, 8'h3C, 1'b0, 10, 8'h3C);
    chk("a5_cs_first", cs_first_a, 1);
    chk("a5_cs_last", cs_last_a, 68);
    chk("a5_first_rise", first_rise_a, 5);
    chk("a5_recv_val_cycle", rv_first_a, 69);
    chk("a5_cs_sel0", cs_seen_a, 2'b10);

    run_a("sel1", 8'h0F, 8'hF0, 1'b1, 0, 8'hF0);
    chk("sel1_cs", cs_seen_a, 2'b01);

    // Reset asserted in cycle 20 of a transfer.
    resp_a = 8'h77; send_msg_a = 8'h99; cs_addr_a = 1'b0; send_val_a = 1'b1;
    @(posedge clk); #1;
    send_val_a = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("midrst_cs_before", spi_cs_a, 2'b10);
    reset = 1'b1;
    #1;
    chk("midrst_rdy", send_rdy_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_outs", {spi_cs_a, spi_sclk_a, recv_val_a}, {2'b11, 1'b0, 1'b0});
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (recv_val_a || spi_cs_a != 2'b11) seen = 1;
    end
    chk("midrst_discarded", seen, 0);

    run_a("5a", 8'h5A, 8'hC3, 1'b0, 0, 8'hC3);
    run_a("c3", 8'hC3, 8'h5A, 1'b1, 0, 8'h5A);

    const_mode = 1'b1; const_val = 1'b1;
    run_a("const1", 8'h12, 8'h00, 1'b0, 0, 8'hFF);
    const_val = 1'b0;
    run_a("const0", 8'hED, 8'hFF, 1'b0, 0, 8'h00);
    const_mode = 1'b0;

    run_b("lb96", 8'h96, 1'b0, 17);
    run_b("lb3b_nocs", 8'h3B, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_xfer.md
# spi_master_xfer

SPI controller-side transfer engine: takes an nbits word on a val/rdy request interface, drives spi_cs/spi_sclk/spi_mosi as an SPI mode-0 (CPOL=0, CPHA=0, MSB first) initiator, samples spi_miso, and returns the received word on a val/rdy response interface. It is the initiator that talks to the team's SPI minion, whose input synchronizers oversample these lines with the system clock. Everything is generated from the single system clock; there is no internal clock domain.

## Interface
- nbits, 8: transfer word width; ≥2.
- half_period, 4: system-clock cycles per SCLK half period; ≥1. Use ≥4 when driving the 3-stage-synchronized minion.
- ncs, 1: number of active-low chip selects; ≥1.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- send_val  input  1  request valid.
- send_rdy  output  1  request ready.
- send_msg  input  nbits  word to transmit.
- cs_addr  input  max(1,$clog2(ncs))  chip-select index, captured with send_msg.
- recv_val  output  1  response valid.
- recv_rdy  input  1  response ready.
- recv_msg  output  nbits  received word.
- spi_sclk  output  1  serial clock, idles 0.
- spi_cs  output  ncs  active-low chip selects, idle all 1.
- spi_mosi  output  1  serial data out.
- spi_miso  input  1  serial data in.

## Operation
- States: IDLE, SETUP, HIGH, LOW, HOLD, DONE. Phase counter (0..half_period-1) and bit counter (0..nbits-1).
- IDLE: send_rdy=1. On send_val&send_rdy: load shift register with send_msg, latch cs_addr, clear counters → SETUP.
- SETUP: spi_cs[cs_addr]=0, sclk=0, mosi=shreg MSB; half_period cycles → HIGH.
- HIGH: sclk=1. On entry cycle, capture miso into a sample bit. After half_period cycles: shift shreg left, sample bit into LSB; if bit counter = nbits-1 → HOLD, else increment → LOW.
- LOW: sclk=0, mosi=new MSB (MOSI changes only on SCLK falling edge); half_period cycles → HIGH.
- HOLD: sclk=0, cs still asserted; half_period cycles → DONE.
- DONE: all cs high, recv_val=1, recv_msg=shreg; on recv_rdy → IDLE.
- send_rdy=1 only in IDLE and not in reset; recv_val=1 only in DONE. No request accepted while a response is pending.
- cs_addr ≥ ncs: no chip select asserted; transfer still clocks nbits bits, result returned normally.
- spi_mosi=0 in IDLE and DONE. All SPI outputs registered (glitch-free).

## Timing
- Reset values (cycle after reset high): state IDLE, spi_sclk=0, spi_cs=all 1, spi_mosi=0, recv_val=0, recv_msg=0; send_rdy=0 while reset asserted.
- Cycle 0 = request handshake cycle. cs asserted cycles 1..(2·nbits+1)·half_period; recv_val first high cycle (2·nbits+1)·half_period+1 (nbits=8, half_period=4: cs low cycles 1..68, recv_val at 69).
- Exactly nbits SCLK rising edges per transfer; first at cycle half_period+1.
- send_rdy reasserts the cycle after the response handshake.
- Reset mid-transfer: next cycle all reset values; transfer discarded, no recv_val.

## Configuration
- SPI_MASTER_MISO_SYNC_EN defined: spi_miso passes through a 2-flop synchronizer before the HIGH-entry capture; capture point unchanged in state terms, effective MISO sample is 2 cycles earlier data. Requires half_period ≥ 3 for minion-driven data to settle.
- Undefined: spi_miso captured directly; no extra flops.

## Test plan
- nbits=8, half_period=4, send 0xA5, minion model returns 0x3C → MOSI at 8 rising edges = 1,0,1,0,0,1,0,1; recv_msg=0x3C; recv_val at cycle 69.
- recv_rdy held low 10 cycles after recv_val → recv_val/recv_msg stable, send_rdy=0, spi_cs=all 1; then IDLE cycle after handshake.
- ncs=2, cs_addr=1 → spi_cs=2'b01 during transfer, 2'b11 before/after; cs_addr=0 → 2'b10.
- reset at cycle 20 of a transfer → cycle 21 spi_cs=all 1, sclk=0, no recv_val; following transfer 0x5A/0xC3 correct.
- half_period=1, nbits=8 → cs low exactly 17 cycles, sclk toggles every cycle, loopback (miso=mosi) returns send_msg.
- SPI_MASTER_MISO_SYNC_EN on, half_period=4, miso constant 1 then 0 → recv_msg 0xFF then 0x00.
